rs_latch_writer: RTL and testbench
==================================

// Module: rs_latch_writer
// PURPOSE
//  Synchronous command-side driver for a gated RS NAND latch: turns one set/reset/hold
//  request into a timed S/R + gate-enable sequence, then reads back Q/Qn to confirm the write.
//  Sits between control logic (valid/ready request port) and the latch S, R and EN inputs.
//  Guarantees S and R are never driven high together and reports done/error per request.
// PARAMETERS
//  SETUP_CYC    1   cycles S/R stable with EN low before the gate pulse (>=1)
//  PULSE_CYC    2   cycles EN held high (>=1)
//  HOLD_CYC     1   cycles S/R held after EN drops (>=0)
//  TIMEOUT_CYC  8   max cycles waiting for Q/Qn to match target in CHECK (>=1)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  synchronous, active-low reset
//  req_valid  in   1  request present
//  req_op     in   2  00=HOLD (read only), 01=SET, 10=RESET, 11=illegal
//  req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
//  s_out      out  1  latch S input (active high)
//  r_out      out  1  latch R input (active high)
//  en_out     out  1  latch gate enable (active high)
//  q_in       in   1  latch Q feedback
//  qn_in      in   1  latch Qn feedback
//  done       out  1  one-cycle pulse: request completed, Q verified
//  err        out  1  one-cycle pulse: illegal op, timeout, or Q==Qn at read-back
//  q_sample   out  1  registered Q captured on the done/err cycle; holds until next capture
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, s_out=r_out=en_out=0, done=err=0, q_sample=0,
//   counters=0; req_ready=1 on the first cycle after reset. Reset mid-sequence aborts at once,
//   no done/err pulse for the aborted request.
//  All outputs are registered. States: IDLE, SETUP, PULSE, HOLD, CHECK, FIN.
//  IDLE: accept on valid&ready; latch op into target register.
//   SET/RESET -> SETUP; s_out=(op==01), r_out=(op==10) from next cycle.
//   HOLD -> CHECK directly, no S/R/EN activity; target = current q_in (verify only Q!=Qn).
//   op 11 -> FIN with err=1, no S/R/EN activity.
//  SETUP: SETUP_CYC cycles, en_out=0 -> PULSE.
//  PULSE: PULSE_CYC cycles, en_out=1, S/R unchanged -> HOLD (or CHECK if HOLD_CYC=0).
//  HOLD: HOLD_CYC cycles, en_out=0, S/R unchanged -> CHECK; s_out=r_out=0 on CHECK entry.
//  CHECK: each cycle compare; pass when q_in==target && qn_in==~target -> FIN, done=1.
//   q_in==qn_in on any CHECK cycle -> FIN, err=1 immediately.
//   No pass after TIMEOUT_CYC cycles -> FIN, err=1.
//  FIN: done or err high for exactly this one cycle; q_sample<=q_in; -> IDLE.
//  done and err never high together; s_out&r_out never 1 (assertion).
//  Latency SET/RESET with ideal latch: SETUP_CYC+PULSE_CYC+HOLD_CYC+1(CHECK)+1(FIN) cycles
//   from accept to done; defaults = 6. HOLD op: 2 cycles. Illegal op: 1 cycle.
//  req_valid during non-IDLE is ignored (ready=0); back-to-back requests: next accept
//   occurs the cycle after FIN. Counters sized $clog2(max param+1), no wrap.
//  en_out is high only in PULSE; s_out/r_out change only on IDLE->SETUP and HOLD/PULSE->CHECK.
// TESTING
//  1 Reset, then SET with latch model Q=0 -> s_out=1,r_out=0 for 4 cycles, en_out=1 for
//    cycles 2-3, done pulse at cycle 6, q_sample=1, err=0.
//  2 RESET after SET -> r_out=1 s_out=0 sequence; done at cycle 6, q_sample=0.
//  3 op=11 -> err pulse 1 cycle after accept, s_out/r_out/en_out stay 0, ready back next cycle.
//  4 SET with latch model stuck Q=0,Qn=1 -> err after TIMEOUT_CYC=8 CHECK cycles, no done.
//  5 HOLD with Q=1,Qn=0 -> done 2 cycles after accept, q_sample=1, en_out never high;
//    repeat with Q=Qn=1 -> err.
//  6 rst_n low during PULSE -> next cycle all outputs 0, state IDLE, no done/err; random
//    back-to-back ops with assertion s_out&r_out==0 and done&err==0 throughout.

Source files
------------

// File: rtl/rs_latch_writer.sv
// Command-side sequencer for a gated RS NAND latch.
// Drives S/R around a timed EN pulse, then verifies Q/Qn.
module rs_latch_writer #(
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 2,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       s_out,
  output logic       r_out,
  output logic       en_out,
  input  logic       q_in,
  input  logic       qn_in,
  output logic       done,
  output logic       err,
  output logic       q_sample
);

  localparam int M1 =
    SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
  localparam int M2 =
    HOLD_CYC > TIMEOUT_CYC ? HOLD_CYC : TIMEOUT_CYC;
  localparam int MX = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] SU_LAST =
    CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PU_LAST =
    CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HO_LAST =
    CW'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, CHECK, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tgt_q, tgt_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          qs_q, qs_d;
  logic          rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    s_d     = s_q;
    r_d     = r_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    qs_d    = qs_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          unique case (req_op)
            2'b01: begin
              s_d     = 1'b1;
              tgt_d   = 1'b1;
              state_d = SETUP;
            end
            2'b10: begin
              r_d     = 1'b1;
              tgt_d   = 1'b0;
              state_d = SETUP;
            end
            2'b00: begin
              tgt_d   = q_in;
              state_d = CHECK;
            end
            default: begin
              err_d   = 1'b1;
              qs_d    = q_in;
              state_d = FIN;
            end
          endcase
        end
      end
      SETUP: begin
        if (cnt_q == SU_LAST) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == PU_LAST) begin
          cnt_d = '0;
          if (HOLD_CYC == 0) begin
            s_d     = 1'b0;
            r_d     = 1'b0;
            state_d = CHECK;
          end else begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HO_LAST) begin
          cnt_d   = '0;
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        // A metastable or broken latch shows Q==Qn
        if (q_in == qn_in) begin
          err_d   = 1'b1;
          qs_d    = q_in;
          state_d = FIN;
        end else if (q_in == tgt_q) begin
          done_d  = 1'b1;
          qs_d    = q_in;
          state_d = FIN;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          qs_d    = q_in;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      qs_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      qs_q    <= qs_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(s_q && r_q));
      assert (!(done_q && err_q));
    end
  end

  assign req_ready = rdy_q;
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign en_out    = en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign q_sample  = qs_q;

endmodule

// File: tb/tb_rs_latch_writer.sv
// Directed bench for rs_latch_writer with a gated
// RS latch model that can be forced into fault modes.
module tb_rs_latch_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic       req_ready;
  logic       s_out, r_out, en_out;
  logic       q_in, qn_in;
  logic       done, err, q_sample;

  int n_vec = 0;
  int n_bad = 0;

  // 0 model, 1 Q0/Qn1, 2 Q1/Qn1, 3 Q1/Qn0
  int   mode = 0;
  logic lq = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (en_out) begin
      if (s_out) lq <= 1'b1;
      else if (r_out) lq <= 1'b0;
    end

  always_comb begin
    q_in  = lq;
    qn_in = ~lq;
    case (mode)
      1: begin q_in = 1'b0; qn_in = 1'b1; end
      2: begin q_in = 1'b1; qn_in = 1'b1; end
      3: begin q_in = 1'b1; qn_in = 1'b0; end
      default: ;
    endcase
  end

  rs_latch_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .s_out     (s_out),
    .r_out     (r_out),
    .en_out    (en_out),
    .q_in      (q_in),
    .qn_in     (qn_in),
    .done      (done),
    .err       (err),
    .q_sample  (q_sample)
  );

  task automatic chk(input string tag,
                     input logic got,
                     input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic issue(input logic [1:0] op);
    @(negedge clk);
    chk("ready_at_issue", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Expected 6-cycle trace, bit k-1 is cycle k
  task automatic run_sr(input logic [1:0] op,
                        input logic qexp);
    logic [5:0] es, er, ee, ed;
    es = (op == 2'b01) ? 6'b001111 : 6'b000000;
    er = (op == 2'b10) ? 6'b001111 : 6'b000000;
    ee = 6'b000110;
    ed = 6'b100000;
    issue(op);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("s_c%0d", k), s_out, es[k-1]);
      chk($sformatf("r_c%0d", k), r_out, er[k-1]);
      chk($sformatf("en_c%0d", k), en_out, ee[k-1]);
      chk($sformatf("done_c%0d", k), done, ed[k-1]);
      chk($sformatf("err_c%0d", k), err, 1'b0);
    end
    chk("qsample_sr", q_sample, qexp);
    @(negedge clk);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin : main
    logic [1:0] op;
    logic       exp_q;
    logic       fin;
    int         ndone;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_s", s_out, 1'b0);
    chk("rst_r", r_out, 1'b0);
    chk("rst_en", en_out, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_qs", q_sample, 1'b0);
    rst_n = 1'b1;

    run_sr(2'b01, 1'b1);
    run_sr(2'b10, 1'b0);

    issue(2'b11);
    @(negedge clk);
    chk("ill_err", err, 1'b1);
    chk("ill_done", done, 1'b0);
    chk("ill_s", s_out, 1'b0);
    chk("ill_r", r_out, 1'b0);
    chk("ill_en", en_out, 1'b0);
    chk("ill_ready1", req_ready, 1'b0);
    @(negedge clk);
    chk("ill_ready2", req_ready, 1'b1);
    chk("ill_err2", err, 1'b0);

    mode = 1;
    issue(2'b01);
    ndone = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == 12) chk("to_err_c12", err, 1'b0);
      if (k == 13) chk("to_err_c13", err, 1'b1);
    end
    chk("to_nodone", ndone != 0, 1'b0);

    mode = 3;
    issue(2'b00);
    @(negedge clk);
    chk("hold_en1", en_out, 1'b0);
    chk("hold_done1", done, 1'b0);
    @(negedge clk);
    chk("hold_done2", done, 1'b1);
    chk("hold_err2", err, 1'b0);
    chk("hold_en2", en_out, 1'b0);
    chk("hold_qs", q_sample, 1'b1);

    mode = 2;
    issue(2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("holdbad_err", err, 1'b1);
    chk("holdbad_done", done, 1'b0);

    mode = 0;
    issue(2'b01);
    @(negedge clk);
    @(negedge clk);
    chk("abort_en_pulse", en_out, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_s", s_out, 1'b0);
    chk("abort_r", r_out, 1'b0);
    chk("abort_en", en_out, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_err", err, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_quiet", done | err, 1'b0);
    end

    // latch was written to 1 during the stuck-Q SET pulse
    exp_q = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 2));
      if (op == 2'b01) exp_q = 1'b1;
      if (op == 2'b10) exp_q = 1'b0;
      issue(op);
      fin = 1'b0;
      for (int k = 1; k <= 20 && !fin; k++) begin
        @(negedge clk);
        chk("rnd_sr_excl", s_out & r_out, 1'b0);
        chk("rnd_de_excl", done & err, 1'b0);
        if (done | err) fin = 1'b1;
      end
      chk("rnd_timeout", fin, 1'b1);
      chk("rnd_done", done, 1'b1);
      chk("rnd_qs", q_sample, exp_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
